// File: rtl/cs_loader.sv
// Control-store loader: copies 256 microcode words from EPROM into RAM, optionally
// reads them back to verify, then hands the shared address bus to the sequencer.
//
//   state   | meaning
//   FETCH   | drive ld_addr to EPROM for SETTLE cycles, capture word on the last one
//   WRITE   | single-cycle active-low RAM write strobe
//   RECOVER | strobe released, address held for RAM hold time; advance or finish copy
//   VREAD   | drive ld_addr for SETTLE cycles to read RAM and EPROM together
//   VCMP    | compare RAM against EPROM word; mismatch aborts to ERROR
//   DONE    | control store valid, sequencer owns cs_addr
//   ERROR   | verify failed, cs_addr shows first bad address, sequencer held off
module cs_loader #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned VERIFY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  seq_addr,
  input  logic [63:0] rom_data,
  input  logic [63:0] ram_rdata,
  output logic [7:0]  cs_addr,
  output logic [63:0] ram_wdata,
  output logic        ram__w,
  output logic        cs_ready,
  output logic        busy,
  output logic        verify_err,
  output logic [7:0]  err_addr
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_WRITE   = 3'd1,
    S_RECOVER = 3'd2,
    S_VREAD   = 3'd3,
    S_VCMP    = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  localparam logic [1:0] C_WAIT_LAST = 2'(SETTLE - 1);
  localparam bit         C_VERIFY_ON = (VERIFY != 0);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_ld_addr;
  logic [1:0]  r_wait;
  logic [63:0] r_ram_wdata;
  logic        r_ram_w_n;
  logic        r_cs_ready;
  logic        r_verify_err;
  logic [7:0]  r_err_addr;
  logic        w_wait_last;
  logic        w_last_word;
  logic        w_vmatch;

  assign w_wait_last = (r_wait == C_WAIT_LAST);
  assign w_last_word = (r_ld_addr == 8'hFF);
  assign w_vmatch    = (ram_rdata == rom_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:   if (w_wait_last) w_next_state = S_WRITE;
      S_WRITE:   w_next_state = S_RECOVER;
      S_RECOVER: begin
        if (w_last_word) w_next_state = C_VERIFY_ON ? S_VREAD : S_DONE;
        else             w_next_state = S_FETCH;
      end
      S_VREAD:   if (w_wait_last) w_next_state = S_VCMP;
      S_VCMP: begin
        if (!w_vmatch)        w_next_state = S_ERROR;
        else if (w_last_word) w_next_state = S_DONE;
        else                  w_next_state = S_VREAD;
      end
      S_DONE, S_ERROR: if (start) w_next_state = S_FETCH;
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Strobe and ready are decoded from the next state so they leave flops cleanly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld_addr    <= 8'h00;
      r_wait       <= 2'd0;
      r_ram_wdata  <= 64'd0;
      r_ram_w_n    <= 1'b1;
      r_cs_ready   <= 1'b0;
      r_verify_err <= 1'b0;
      r_err_addr   <= 8'h00;
    end else begin
      r_ram_w_n  <= (w_next_state != S_WRITE);
      r_cs_ready <= (w_next_state == S_DONE);
      case (r_state)
        S_FETCH: begin
          if (w_wait_last) begin
            r_wait      <= 2'd0;
            r_ram_wdata <= rom_data;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_RECOVER: r_ld_addr <= r_ld_addr + 8'd1;
        S_VREAD: begin
          if (w_wait_last) r_wait <= 2'd0;
          else             r_wait <= r_wait + 2'd1;
        end
        S_VCMP: begin
          if (!w_vmatch) begin
            r_verify_err <= 1'b1;
            r_err_addr   <= r_ld_addr;
          end else begin
            r_ld_addr <= r_ld_addr + 8'd1;
          end
        end
        S_DONE, S_ERROR: begin
          if (start) begin
            r_ld_addr    <= 8'h00;
            r_wait       <= 2'd0;
            r_verify_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cs_addr = r_ld_addr;
    if (r_state == S_DONE)       cs_addr = seq_addr;
    else if (r_state == S_ERROR) cs_addr = r_err_addr;
  end

  assign busy       = (r_state != S_DONE) && (r_state != S_ERROR);
  assign ram_wdata  = r_ram_wdata;
  assign ram__w     = r_ram_w_n;
  assign cs_ready   = r_cs_ready;
  assign verify_err = r_verify_err;
  assign err_addr   = r_err_addr;

endmodule

// File: tb/tb_cs_loader.sv
// Directed bench for cs_loader: one instance with verify (SETTLE=1) and one
// without verify (SETTLE=3), each with an EPROM of word n = {8{n}} and a RAM model.
module tb_cs_loader;

  logic        clk;
  logic        rst_a, rst_b;
  logic        start_a, start_b;
  logic [7:0]  seq_a, seq_b;
  logic [63:0] rom_a, rom_b, rdata_a, rdata_b;
  logic [7:0]  cs_addr_a, cs_addr_b, err_addr_a, err_addr_b;
  logic [63:0] wdata_a, wdata_b;
  logic        ram_w_a, ram_w_b, ready_a, ready_b, busy_a, busy_b, verr_a, verr_b;

  logic [63:0] mem_a [256];
  logic [63:0] mem_b [256];
  logic        corrupt;

  int n_asserts = 0;
  int n_fail    = 0;
  int wr_cnt_a  = 0;
  int wr_cnt_b  = 0;

  logic       prev_w_a, prev_w_b;
  logic [7:0] prev_addr_a, prev_addr_b, exp_wr_a, exp_wr_b;

  cs_loader #(.SETTLE(1), .VERIFY(1)) u_dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .seq_addr(seq_a),
    .rom_data(rom_a), .ram_rdata(rdata_a), .cs_addr(cs_addr_a),
    .ram_wdata(wdata_a), .ram__w(ram_w_a), .cs_ready(ready_a), .busy(busy_a),
    .verify_err(verr_a), .err_addr(err_addr_a)
  );

  cs_loader #(.SETTLE(3), .VERIFY(0)) u_dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .seq_addr(seq_b),
    .rom_data(rom_b), .ram_rdata(rdata_b), .cs_addr(cs_addr_b),
    .ram_wdata(wdata_b), .ram__w(ram_w_b), .cs_ready(ready_b), .busy(busy_b),
    .verify_err(verr_b), .err_addr(err_addr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign rom_a   = {8{cs_addr_a}};
  assign rom_b   = {8{cs_addr_b}};
  assign rdata_a = mem_a[cs_addr_a] ^ ((corrupt && cs_addr_a == 8'h5A) ? 64'h1 : 64'h0);
  assign rdata_b = mem_b[cs_addr_b];

  always @(posedge clk) begin
    if (!ram_w_a) mem_a[cs_addr_a] <= wdata_a;
    if (!ram_w_b) mem_b[cs_addr_b] <= wdata_b;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Write-strobe protocol: single-cycle low pulses, sequential addresses, hold on release.
  always @(negedge clk) begin
    if (rst_a) begin
      prev_w_a = 1'b1; exp_wr_a = 8'h00;
    end else begin
      if (!ram_w_a) begin
        check("wr_pulse_width_a", {63'd0, prev_w_a}, 64'd1);
        check("wr_addr_a", {56'd0, cs_addr_a}, {56'd0, exp_wr_a});
        check("wr_data_a", wdata_a, {8{exp_wr_a}});
        exp_wr_a = exp_wr_a + 8'd1;
        wr_cnt_a++;
      end else if (!prev_w_a) begin
        check("hold_addr_a", {56'd0, cs_addr_a}, {56'd0, prev_addr_a});
      end
      prev_w_a = ram_w_a; prev_addr_a = cs_addr_a;
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      prev_w_b = 1'b1; exp_wr_b = 8'h00;
    end else begin
      if (!ram_w_b) begin
        check("wr_pulse_width_b", {63'd0, prev_w_b}, 64'd1);
        check("wr_addr_b", {56'd0, cs_addr_b}, {56'd0, exp_wr_b});
        check("wr_data_b", wdata_b, {8{exp_wr_b}});
        exp_wr_b = exp_wr_b + 8'd1;
        wr_cnt_b++;
      end else if (!prev_w_b) begin
        check("hold_addr_b", {56'd0, cs_addr_b}, {56'd0, prev_addr_b});
      end
      prev_w_b = ram_w_b; prev_addr_b = cs_addr_b;
    end
  end

  initial begin
    int  bad;
    bit  found;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    seq_a = 8'h00; seq_b = 8'h00; corrupt = 1'b0;
    tick(2);

    check("rst_cs_addr", {56'd0, cs_addr_a}, 64'h00);
    check("rst_wdata", wdata_a, 64'd0);
    check("rst_ram_w", {63'd0, ram_w_a}, 64'd1);
    check("rst_ready", {63'd0, ready_a}, 64'd0);
    check("rst_busy", {63'd0, busy_a}, 64'd1);
    check("rst_verr", {63'd0, verr_a}, 64'd0);
    check("rst_err_addr", {56'd0, err_addr_a}, 64'h00);
    check("rst_ram_w_b", {63'd0, ram_w_b}, 64'd1);
    check("rst_busy_b", {63'd0, busy_b}, 64'd1);

    // Full load on both instances; a start pulse mid-load must not disturb timing.
    rst_a = 1'b0; rst_b = 1'b0; wr_cnt_a = 0; wr_cnt_b = 0;
    tick(100);
    start_a = 1'b1; start_b = 1'b1;
    tick(1);
    start_a = 1'b0; start_b = 1'b0;
    tick(1178);
    check("ready_a_at_1279", {63'd0, ready_a}, 64'd0);
    check("busy_a_at_1279", {63'd0, busy_a}, 64'd1);
    check("ready_b_at_1279", {63'd0, ready_b}, 64'd0);
    tick(1);
    check("ready_a_at_1280", {63'd0, ready_a}, 64'd1);
    check("busy_a_done", {63'd0, busy_a}, 64'd0);
    check("verr_a_clean", {63'd0, verr_a}, 64'd0);
    check("ready_b_at_1280", {63'd0, ready_b}, 64'd1);
    check("busy_b_done", {63'd0, busy_b}, 64'd0);
    check("wr_count_a", 64'(wr_cnt_a), 64'd256);
    check("wr_count_b", 64'(wr_cnt_b), 64'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem_a[i] !== {8{8'(i)}}) bad++;
      if (mem_b[i] !== {8{8'(i)}}) bad++;
    end
    check("ram_contents", 64'(bad), 64'd0);

    // DONE: sequencer address passes straight through.
    seq_a = 8'hA7; seq_b = 8'h11;
    #1;
    check("seq_pass_a7", {56'd0, cs_addr_a}, 64'hA7);
    check("seq_pass_b", {56'd0, cs_addr_b}, 64'h11);
    seq_a = 8'h3C;
    #1;
    check("seq_pass_3c", {56'd0, cs_addr_a}, 64'h3C);

    // Reload with RAM word 0x5A reading back corrupted.
    corrupt = 1'b1;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0; wr_cnt_a = 0;
    check("reload_ready_low", {63'd0, ready_a}, 64'd0);
    check("reload_cs_addr", {56'd0, cs_addr_a}, 64'h00);
    check("reload_busy", {63'd0, busy_a}, 64'd1);
    tick(949);
    check("busy_before_err", {63'd0, busy_a}, 64'd1);
    check("verr_before_err", {63'd0, verr_a}, 64'd0);
    tick(1);
    check("err_busy", {63'd0, busy_a}, 64'd0);
    check("err_verr", {63'd0, verr_a}, 64'd1);
    check("err_addr", {56'd0, err_addr_a}, 64'h5A);
    check("err_ready", {63'd0, ready_a}, 64'd0);
    check("err_cs_addr", {56'd0, cs_addr_a}, 64'h5A);
    check("err_wr_count", 64'(wr_cnt_a), 64'd256);
    tick(5);
    check("err_hold_ready", {63'd0, ready_a}, 64'd0);
    check("err_hold_verr", {63'd0, verr_a}, 64'd1);
    check("err_hold_busy", {63'd0, busy_a}, 64'd0);

    // Recover from ERROR with a clean RAM.
    corrupt = 1'b0;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    check("recover_verr_clr", {63'd0, verr_a}, 64'd0);
    check("recover_err_addr", {56'd0, err_addr_a}, 64'h5A);
    check("recover_busy", {63'd0, busy_a}, 64'd1);
    check("recover_cs_addr", {56'd0, cs_addr_a}, 64'h00);
    tick(1279);
    check("recover_ready_1279", {63'd0, ready_a}, 64'd0);
    tick(1);
    check("recover_ready_1280", {63'd0, ready_a}, 64'd1);
    check("recover_verr_done", {63'd0, verr_a}, 64'd0);

    // Reset in the middle of the write strobe for word 0x40.
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick(1);
      if (!ram_w_a && cs_addr_a == 8'h40) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_write_0x40", {63'd0, found}, 64'd1);
    rst_a = 1'b1;
    #1;
    check("async_ram_w_high", {63'd0, ram_w_a}, 64'd1);
    check("async_cs_addr", {56'd0, cs_addr_a}, 64'h00);
    check("async_wdata", wdata_a, 64'd0);
    check("async_busy", {63'd0, busy_a}, 64'd1);
    tick(2);
    rst_a = 1'b0;
    tick(1);
    check("restart_write_strobe", {63'd0, ram_w_a}, 64'd0);
    check("restart_write_addr", {56'd0, cs_addr_a}, 64'h00);
    tick(1279);
    check("restart_ready", {63'd0, ready_a}, 64'd1);
    check("b_still_done", {63'd0, ready_b}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
